// File: rtl/conv_host_mem.sv
// conv_host_mem: memory-side responder for the CONV accelerator.
//   Holds IMG (4096x20), L0 (4096x20) and L1 (1024x20). It loads IMG from a
//   host stream, kicks the accelerator with a one-cycle ready, serves image
//   and layer accesses, then streams L1 back to the host.
// Ports:
//   clk, reset (async, active-high), start
//   load_valid/load_data/load_ready : host image stream in
//   ready/busy                      : accelerator kick / busy
//   iaddr/idata                     : image read port (combinational)
//   cwr/caddr_wr/cdata_wr           : layer write port (synchronous)
//   crd/caddr_rd/cdata_rd           : layer read port (combinational)
//   csel                            : layer select, 1=L0, 3=L1
//   dump_valid/dump_data/dump_last/dump_ready : L1 stream out
//   done, err_timeout, err_csel     : status (errors sticky until start)
module conv_host_mem #(
   parameter int RUN_TIMEOUT = 200000,
   parameter int CNT_W       = 18
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        load_valid,
   input  logic [19:0] load_data,
   output logic        load_ready,
   output logic        ready,
   input  logic        busy,
   input  logic [11:0] iaddr,
   output logic [19:0] idata,
   input  logic        cwr,
   input  logic [11:0] caddr_wr,
   input  logic [19:0] cdata_wr,
   input  logic        crd,
   input  logic [11:0] caddr_rd,
   output logic [19:0] cdata_rd,
   input  logic [2:0]  csel,
   output logic        dump_valid,
   output logic [19:0] dump_data,
   output logic        dump_last,
   input  logic        dump_ready,
   output logic        done,
   output logic        err_timeout,
   output logic        err_csel
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_KICK, S_WAIT, S_RUN, S_DUMP, S_DONE
   } state_t;

   // The counter reads 0 in the first cycle after ready, so firing at
   // RUN_TIMEOUT-2 lands DONE exactly RUN_TIMEOUT cycles after the ready cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_TIMEOUT - 2);

   state_t           state_q;
   logic [11:0]      ladr_q;
   logic [9:0]       dadr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             err_timeout_q, err_csel_q;

   logic [19:0] img [4096];
   logic [19:0] l0  [4096];
   logic [19:0] l1  [1024];

   logic bad_wr, start_acc, load_xfer, dump_xfer, to_hit;

   assign bad_wr    = cwr && (csel != 3'd1) && (csel != 3'd3);
   assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign load_xfer = (state_q == S_LOAD) && load_valid;
   assign dump_xfer = (state_q == S_DUMP) && dump_ready;
   assign to_hit    = (cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         ladr_q        <= '0;
         dadr_q        <= '0;
         cnt_q         <= '0;
         err_timeout_q <= 1'b0;
         err_csel_q    <= 1'b0;
      end else begin
         // A bad write in the same cycle as start still latches.
         err_csel_q <= (start_acc ? 1'b0 : err_csel_q) | bad_wr;
         case (state_q)
            S_IDLE, S_DONE: if (start) begin
               state_q       <= S_LOAD;
               ladr_q        <= '0;
               dadr_q        <= '0;
               cnt_q         <= '0;
               err_timeout_q <= 1'b0;
            end
            S_LOAD: if (load_valid) begin
               ladr_q <= ladr_q + 12'd1;
               if (ladr_q == 12'd4095) state_q <= S_KICK;
            end
            S_KICK: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT, S_RUN: begin
               cnt_q <= cnt_q + 1'b1;
               if (to_hit) begin
                  err_timeout_q <= 1'b1;
                  state_q       <= S_DONE;
               end else if ((state_q == S_WAIT) && busy) begin
                  state_q <= S_RUN;
               end else if ((state_q == S_RUN) && !busy) begin
                  state_q <= S_DUMP;
               end
            end
            S_DUMP: if (dump_ready) begin
               dadr_q <= dadr_q + 10'd1;
               if (dadr_q == 10'd1023) state_q <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Memories are not reset; contents survive reset.
   always_ff @(posedge clk) if (load_xfer) img[ladr_q] <= load_data;
   always_ff @(posedge clk) if (cwr && (csel == 3'd1)) l0[caddr_wr] <= cdata_wr;
   always_ff @(posedge clk) if (cwr && (csel == 3'd3)) l1[caddr_wr[9:0]] <= cdata_wr;

   assign idata = img[iaddr];

   always_comb begin
      cdata_rd = '0;
      if (crd && (csel == 3'd1)) cdata_rd = l0[caddr_rd];
      else if (crd && (csel == 3'd3)) cdata_rd = l1[caddr_rd[9:0]];
   end

   assign load_ready  = (state_q == S_LOAD);
   assign ready       = (state_q == S_KICK);
   assign dump_valid  = (state_q == S_DUMP);
   assign dump_last   = (state_q == S_DUMP) && (dadr_q == 10'd1023);
   assign dump_data   = l1[dadr_q];
   assign done        = (state_q == S_DONE);
   assign err_timeout = err_timeout_q;
   assign err_csel    = err_csel_q;

   logic unused_dump;
   assign unused_dump = dump_xfer;

endmodule

// File: tb/tb_conv_host_mem.sv
// tb_conv_host_mem: directed bench for conv_host_mem with a short run
// timeout so both the normal run and the timeout path finish quickly.
module tb_conv_host_mem;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        load_valid = 1'b0;
   logic [19:0] load_data = '0;
   logic        load_ready, ready;
   logic        busy = 1'b0;
   logic [11:0] iaddr = '0;
   logic [19:0] idata;
   logic        cwr = 1'b0;
   logic [11:0] caddr_wr = '0;
   logic [19:0] cdata_wr = '0;
   logic        crd = 1'b0;
   logic [11:0] caddr_rd = '0;
   logic [19:0] cdata_rd;
   logic [2:0]  csel = 3'd0;
   logic        dump_valid, dump_last, done, err_timeout, err_csel;
   logic [19:0] dump_data;
   logic        dump_ready = 1'b0;

   int checks = 0;
   int failures = 0;

   conv_host_mem #(.RUN_TIMEOUT(50), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .start(start),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
      .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
      .dump_valid(dump_valid), .dump_data(dump_data), .dump_last(dump_last),
      .dump_ready(dump_ready), .done(done),
      .err_timeout(err_timeout), .err_csel(err_csel)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks++;
      if ({load_ready, ready, dump_valid, dump_last, done, err_timeout, err_csel} !== 7'b0) begin
         failures++;
         $display("FAIL reset_outputs got=%b want=0000000",
                  {load_ready, ready, dump_valid, dump_last, done, err_timeout, err_csel});
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_layer_port();
      // Fill L1 from IDLE with a known pattern.
      for (int i = 0; i < 1024; i++) begin
         cwr = 1'b1; csel = 3'd3; caddr_wr = 12'(i); cdata_wr = 20'hA0000 | 20'(i);
         tick();
      end
      cwr = 1'b1; csel = 3'd1; caddr_wr = 12'd5; cdata_wr = 20'h12345;
      tick();
      cwr = 1'b0; crd = 1'b1; csel = 3'd1; caddr_rd = 12'd5;
      #1 checks++;
      if (cdata_rd !== 20'h12345) begin
         failures++; $display("FAIL l0_rd5 got=%h want=12345", cdata_rd);
      end
      cwr = 1'b1; csel = 3'd3; caddr_wr = 12'h405; cdata_wr = 20'h12345;
      crd = 1'b0;
      tick();
      cwr = 1'b0; crd = 1'b1; csel = 3'd3; caddr_rd = 12'd5;
      #1 checks++;
      if (cdata_rd !== 20'h12345) begin
         failures++; $display("FAIL l1_rd5 got=%h want=12345", cdata_rd);
      end
      caddr_rd = 12'd6;
      #1 checks++;
      if (cdata_rd !== 20'hA0006) begin
         failures++; $display("FAIL l1_rd6 got=%h want=a0006", cdata_rd);
      end
      crd = 1'b0;
      #1 checks++;
      if (cdata_rd !== 20'h0) begin
         failures++; $display("FAIL rd_idle got=%h want=00000", cdata_rd);
      end
      // Same-cycle read/write returns old data; new data after the edge.
      cwr = 1'b1; csel = 3'd1; caddr_wr = 12'd7; cdata_wr = 20'h11111;
      tick();
      cdata_wr = 20'h22222; crd = 1'b1; caddr_rd = 12'd7;
      #1 checks++;
      if (cdata_rd !== 20'h11111) begin
         failures++; $display("FAIL rw_old got=%h want=11111", cdata_rd);
      end
      tick();
      cwr = 1'b0;
      #1 checks++;
      if (cdata_rd !== 20'h22222) begin
         failures++; $display("FAIL rw_new got=%h want=22222", cdata_rd);
      end
      checks++;
      if (err_csel !== 1'b0) begin
         failures++; $display("FAIL err_csel_clean got=%b want=0", err_csel);
      end
      cwr = 1'b1; csel = 3'd2; caddr_wr = 12'd5; cdata_wr = 20'hFFFFF; crd = 1'b0;
      tick();
      cwr = 1'b0;
      checks++;
      if (err_csel !== 1'b1) begin
         failures++; $display("FAIL err_csel_set got=%b want=1", err_csel);
      end
      crd = 1'b1; csel = 3'd1; caddr_rd = 12'd5;
      #1 checks++;
      if (cdata_rd !== 20'h12345) begin
         failures++; $display("FAIL csel2_l0 got=%h want=12345", cdata_rd);
      end
      csel = 3'd3;
      #1 checks++;
      if (cdata_rd !== 20'h12345) begin
         failures++; $display("FAIL csel2_l1 got=%h want=12345", cdata_rd);
      end
      crd = 1'b0; csel = 3'd0;
      tick();
   endtask

   task automatic test_reset_mid_load();
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (load_ready !== 1'b1 || err_csel !== 1'b0) begin
         failures++;
         $display("FAIL start_load got lr=%b ec=%b want lr=1 ec=0", load_ready, err_csel);
      end
      load_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         load_data = 20'hF0000 | 20'(k);
         tick();
      end
      #2 reset = 1'b1;
      #1 checks++;
      if ({load_ready, ready, dump_valid, dump_last, done, err_timeout, err_csel} !== 7'b0) begin
         failures++;
         $display("FAIL midload_reset got=%b want=0000000",
                  {load_ready, ready, dump_valid, dump_last, done, err_timeout, err_csel});
      end
      load_valid = 1'b0;
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_load_run();
      int nlr;
      nlr = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      load_valid = 1'b1;
      for (int k = 0; k < 4096; k++) begin
         load_data = 20'(k);
         if (load_ready === 1'b1) nlr++;
         tick();
      end
      load_valid = 1'b0;
      checks++;
      if (nlr != 4096) begin
         failures++; $display("FAIL load_count got=%0d want=4096", nlr);
      end
      checks++;
      if (load_ready !== 1'b0 || ready !== 1'b1) begin
         failures++; $display("FAIL kick got lr=%b rdy=%b want lr=0 rdy=1", load_ready, ready);
      end
      busy = 1'b1;
      tick();
      checks++;
      if (ready !== 1'b0) begin
         failures++; $display("FAIL ready_pulse got=%b want=0", ready);
      end
      iaddr = 12'hABC;
      #1 checks++;
      if (idata !== 20'h00ABC) begin
         failures++; $display("FAIL idata_abc got=%h want=00abc", idata);
      end
      iaddr = 12'd99;
      #1 checks++;
      if (idata !== 20'h00063) begin
         failures++; $display("FAIL idata_99 got=%h want=00063", idata);
      end
      iaddr = 12'd0;
      #1 checks++;
      if (idata !== 20'h00000) begin
         failures++; $display("FAIL idata_0 got=%h want=00000", idata);
      end
      repeat (10) tick();
      checks++;
      if (dump_valid !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL running got dv=%b done=%b want 0 0", dump_valid, done);
      end
      busy = 1'b0;
      tick();
   endtask

   task automatic test_dump_backpressure();
      int n, bad_d, bad_l, bad_s, cyc;
      logic        prev_stall;
      logic [19:0] prev_data, exp_d;
      n = 0; bad_d = 0; bad_l = 0; bad_s = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
      while (n < 1024 && cyc < 5000) begin
         dump_ready = 1'($urandom_range(0, 1));
         #2;
         if (prev_stall && dump_data !== prev_data) bad_s++;
         if (dump_valid === 1'b1) begin
            if (dump_last !== (n == 1023)) bad_l++;
            if (dump_ready) begin
               exp_d = (n == 5) ? 20'h12345 : (20'hA0000 | 20'(n));
               if (dump_data !== exp_d) begin
                  bad_d++;
                  if (bad_d < 4) $display("FAIL dump_word%0d got=%h want=%h", n, dump_data, exp_d);
               end
               n++;
            end
         end
         prev_stall = dump_valid && !dump_ready;
         prev_data  = dump_data;
         cyc++;
         tick();
      end
      dump_ready = 1'b0;
      checks++;
      if (n != 1024) begin
         failures++; $display("FAIL dump_count got=%0d want=1024", n);
      end
      checks++;
      if (bad_d != 0) begin
         failures++; $display("FAIL dump_data bad_words=%0d want=0", bad_d);
      end
      checks++;
      if (bad_l != 0) begin
         failures++; $display("FAIL dump_last bad=%0d want=0", bad_l);
      end
      checks++;
      if (bad_s != 0) begin
         failures++; $display("FAIL dump_stall_stable bad=%0d want=0", bad_s);
      end
      checks++;
      if (done !== 1'b1 || dump_valid !== 1'b0 || err_timeout !== 1'b0) begin
         failures++;
         $display("FAIL dump_done got done=%b dv=%b et=%b want 1 0 0", done, dump_valid, err_timeout);
      end
   endtask

   task automatic test_timeout();
      int bad_done, bad_dv;
      bad_done = 0; bad_dv = 0;
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || load_ready !== 1'b1) begin
         failures++; $display("FAIL restart got done=%b lr=%b want 0 1", done, load_ready);
      end
      load_valid = 1'b1;
      for (int k = 0; k < 4096; k++) begin
         load_data = 20'(k);
         tick();
      end
      load_valid = 1'b0;
      checks++;
      if (ready !== 1'b1) begin
         failures++; $display("FAIL to_kick got=%b want=1", ready);
      end
      for (int k = 1; k <= 55; k++) begin
         tick();
         if (done !== (k >= 50)) begin
            bad_done++;
            $display("FAIL to_done_cyc%0d got=%b want=%b", k, done, (k >= 50));
         end
         if (dump_valid !== 1'b0) bad_dv++;
      end
      checks++;
      if (bad_done != 0) begin
         failures++; $display("FAIL to_done_timing bad=%0d want=0", bad_done);
      end
      checks++;
      if (bad_dv != 0 || err_timeout !== 1'b1) begin
         failures++; $display("FAIL to_flags got dv_bad=%0d et=%b want 0 1", bad_dv, err_timeout);
      end
   endtask

   initial begin
      test_reset();
      test_layer_port();
      test_reset_mid_load();
      test_load_run();
      test_dump_backpressure();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
